operand_entry: RTL and testbench

Front-end operand entry stage for the Basys3 calculator. It takes the four raw digit push-buttons and the operation switches and produces four clean BCD operand digits and a registered operation code. It runs on the board clock, replacing the per-digit counters that feed the adder, multiplier, divider and subtractor, with debounced single-step increments and 9→0 wrap. Its digit outputs feed the arithmetic units and the display path.

---
 rtl/calc_pkg.sv | 45 ++++
 rtl/operand_entry_if.sv | 27 ++
 rtl/btn_debounce.sv | 143 ++++++++++++++
 rtl/operand_entry.sv | 66 ++++++
 tb/tb_operand_entry.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: operation codes, BCD
// limit, debounce FSM state encoding and small helpers used by operand_entry.
package calc_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  // Counter width: enough bits for the largest timing parameter, plus one.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return int'($clog2(m)) + 1;
  endfunction

  // Single BCD step with 9 -> 0 wrap.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  // Priority decode of the operation switches: bit0 wins over bit1, etc.
  function automatic logic [2:0] op_decode(input logic [3:0] sw);
    if (sw[0])      return OP_ADD;
    else if (sw[1]) return OP_MUL;
    else if (sw[2]) return OP_DIV;
    else if (sw[3]) return OP_SUB;
    else            return OP_NONE;
  endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Bus between the operand entry stage and its surroundings.
//   in          raw push-buttons (in[i] steps digit i)
//   operations  raw operation switches
//   digit0..3   BCD operand digits
//   op_code     decoded operation
//   upd         one-cycle pulse on any digit change
// slave: the operand entry stage; master: the environment driving it.
interface operand_entry_if;
  logic [3:0] in;
  logic [3:0] operations;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [2:0] op_code;
  logic       upd;

  modport master (
    output in, operations,
    input  digit0, digit1, digit2, digit3, op_code, upd
  );

  modport slave (
    input  in, operations,
    output digit0, digit1, digit2, digit3, op_code, upd
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-button synchroniser + debounce FSM producing a registered one-cycle
// step pulse when a press is accepted.
//   clk, rstn  clock, async active-low reset
//   raw        asynchronous raw button level
//   step       registered one-cycle pulse per accepted press (or repeat)
// Optional macro AUTOREPEAT_EN: while held in PRESSED, emit a step after
// HOLD_CYCLES and then every REPEAT_CYCLES.
module btn_debounce
  import calc_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 20000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic step
);

  localparam int unsigned  CW   = cnt_width(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB_T = CW'(DB_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);
`ifdef AUTOREPEAT_EN
  localparam logic [CW-1:0] HOLD_T = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_T  = CW'(REPEAT_CYCLES);
`endif

  logic [1:0]    sync_q;
  logic          lvl;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          step_d;
`ifdef AUTOREPEAT_EN
  logic [CW-1:0] hold_q, hold_d, hold_inc;
  logic          rep_q, rep_d;
`endif

  assign lvl     = sync_q[1];
  // Stability counter saturates at its terminal value.
  assign cnt_inc = (cnt_q >= DB_T) ? cnt_q : cnt_q + ONE;
`ifdef AUTOREPEAT_EN
  assign hold_inc = (&hold_q) ? hold_q : hold_q + ONE;
`endif

  // State, counters, synchroniser and step register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b00;
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      step    <= 1'b0;
`ifdef AUTOREPEAT_EN
      hold_q  <= '0;
      rep_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[0], raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step    <= step_d;
`ifdef AUTOREPEAT_EN
      hold_q  <= hold_d;
      rep_q   <= rep_d;
`endif
    end
  end

  // Next-state and step decision; the first differing sample already counts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
`ifdef AUTOREPEAT_EN
    hold_d  = '0;
    rep_d   = 1'b0;
`endif
    case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (lvl) begin
          if (ONE >= DB_T) begin
            state_d = DB_PRESSED;
            step_d  = 1'b1;
          end else begin
            state_d = DB_PRESS_WAIT;
            cnt_d   = ONE;
          end
        end
      end
      DB_PRESS_WAIT: begin
        if (!lvl) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_T) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DB_PRESSED: begin
        cnt_d = '0;
        if (!lvl) begin
          if (ONE >= DB_T) begin
            state_d = DB_IDLE;
          end else begin
            state_d = DB_RELEASE_WAIT;
            cnt_d   = ONE;
          end
        end else begin
`ifdef AUTOREPEAT_EN
          // Hold phase first, then fixed repeat period until release.
          hold_d = hold_inc;
          rep_d  = rep_q;
          if ((!rep_q && hold_inc >= HOLD_T) || (rep_q && hold_inc >= REP_T)) begin
            step_d = 1'b1;
            hold_d = '0;
            rep_d  = 1'b1;
          end
`endif
        end
      end
      DB_RELEASE_WAIT: begin
        if (lvl) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_inc >= DB_T) begin
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = DB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/operand_entry.sv
// Operand entry stage: four debounced digit buttons stepping BCD digits
// 0..9 with wrap, plus a synchronised priority decode of the op switches.
//   clk, rstn  board clock, async active-low reset
//   bus        operand_entry_if.slave: in, operations -> digit0..3, op_code, upd
// Optional macro AUTOREPEAT_EN enables hold-to-repeat in btn_debounce.
module operand_entry
  import calc_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 20000000
) (
  input  logic           clk,
  input  logic           rstn,
  operand_entry_if.slave bus
);

  localparam int unsigned NDIG = 4;

  logic [NDIG-1:0] step;
  logic [3:0]      digit_q [NDIG];
  logic [3:0]      op_sync1_q, op_sync2_q;
  logic [2:0]      op_q;
  logic            upd_q;

  // One debouncer per digit button.
  for (genvar g = 0; g < NDIG; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_db (
      .clk (clk),
      .rstn(rstn),
      .raw (bus.in[g]),
      .step(step[g])
    );
  end

  // Digit registers, update pulse, switch synchroniser and op register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NDIG; i++) digit_q[i] <= 4'd0;
      upd_q      <= 1'b0;
      op_sync1_q <= 4'd0;
      op_sync2_q <= 4'd0;
      op_q       <= OP_NONE;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (step[i]) digit_q[i] <= bcd_inc(digit_q[i]);
      end
      upd_q      <= |step;
      op_sync1_q <= bus.operations;
      op_sync2_q <= op_sync1_q;
      op_q       <= op_decode(op_sync2_q);
    end
  end

  assign bus.digit0  = digit_q[0];
  assign bus.digit1  = digit_q[1];
  assign bus.digit2  = digit_q[2];
  assign bus.digit3  = digit_q[3];
  assign bus.op_code = op_q;
  assign bus.upd     = upd_q;

endmodule

// File: tb/tb_operand_entry.sv
// Testbench for operand_entry: directed scenarios plus randomized button and
// switch activity, compared every cycle against a filtered-level model.
module tb_operand_entry;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 8;
`ifdef AUTOREPEAT_EN
  localparam int HELD_STEPS = 5;
`else
  localparam int HELD_STEPS = 1;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   upd_cnt = 0;

  operand_entry_if bus();

  operand_entry #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int op_of(input logic [3:0] sw);
    if (sw[0]) return 1;
    if (sw[1]) return 2;
    if (sw[2]) return 3;
    if (sw[3]) return 4;
    return 0;
  endfunction

  // Reference model: each button's accepted level flips once the (3-cycle
  // delayed) raw level has disagreed with it for DB consecutive samples; a
  // 0->1 flip is a step that is visible on the digit at that same edge.
  logic [3:0] h1, h2, h3, o1, o2;
  logic [3:0] filt;
  int         run [4];
  int         m_dig [4];
  int         exp_op;
  logic       exp_upd;
`ifdef AUTOREPEAT_EN
  int         ones [4];
  logic [3:0] phase;
`endif

  initial begin
    logic [3:0] stp;
    logic       s;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        h1 = '0; h2 = '0; h3 = '0; o1 = '0; o2 = '0; filt = '0;
        exp_op = 0; exp_upd = 1'b0;
        for (int b = 0; b < 4; b++) begin
          run[b] = 0; m_dig[b] = 0;
`ifdef AUTOREPEAT_EN
          ones[b] = 0; phase[b] = 1'b0;
`endif
        end
      end else begin
        stp = '0;
        for (int b = 0; b < 4; b++) begin
          s = h3[b];
          if (s != filt[b]) begin
            run[b]++;
`ifdef AUTOREPEAT_EN
            if (filt[b]) begin ones[b] = -1; phase[b] = 1'b0; end
`endif
            if (run[b] >= int'(DB)) begin
              filt[b] = s;
              run[b]  = 0;
              if (s) begin
                stp[b] = 1'b1;
`ifdef AUTOREPEAT_EN
                ones[b] = 0; phase[b] = 1'b0;
`endif
              end
            end
          end else begin
            run[b] = 0;
`ifdef AUTOREPEAT_EN
            if (filt[b]) begin
              ones[b]++;
              if ((!phase[b] && ones[b] >= int'(HOLD)) || (phase[b] && ones[b] >= int'(REP))) begin
                stp[b] = 1'b1; ones[b] = 0; phase[b] = 1'b1;
              end
            end
`endif
          end
        end
        h3 = h2; h2 = h1; h1 = bus.in;
        exp_op = op_of(o2); o2 = o1; o1 = bus.operations;
        for (int b = 0; b < 4; b++) if (stp[b]) m_dig[b] = (m_dig[b] + 1) % 10;
        exp_upd = |stp;
      end
      #1;
      check("model_digit0", int'(bus.digit0), m_dig[0]);
      check("model_digit1", int'(bus.digit1), m_dig[1]);
      check("model_digit2", int'(bus.digit2), m_dig[2]);
      check("model_digit3", int'(bus.digit3), m_dig[3]);
      check("model_upd", int'(bus.upd), int'(exp_upd));
      check("model_op_code", int'(bus.op_code), exp_op);
      if (bus.upd === 1'b1) upd_cnt++;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    logic [3:0] t;
    t = bus.in;
    t[b] = v;
    bus.in = t;
  endtask

  initial begin
    int cd [4];
    bus.in = 4'd0;
    bus.operations = 4'd0;
    wait_neg(3);
    rstn = 1'b1;
    wait_neg(2);

    // Reset state
    check("rst_digit0", int'(bus.digit0), 0);
    check("rst_digit3", int'(bus.digit3), 0);
    check("rst_op_code", int'(bus.op_code), 0);
    check("rst_upd", int'(bus.upd), 0);

    // Single press: digit0 changes on the 7th edge after the rise
    upd_cnt = 0;
    set_btn(0, 1'b1);
    repeat (6) @(posedge clk);
    #1 check("press_before_latency", int'(bus.digit0), 0);
    @(posedge clk);
    #1 check("press_at_latency", int'(bus.digit0), 1);
    check("press_upd_high", int'(bus.upd), 1);
    @(posedge clk);
    #1 check("press_upd_one_cycle", int'(bus.upd), 0);
    wait_neg(12);
    set_btn(0, 1'b0);
    wait_neg(10);
    check("press_single_upd", upd_cnt, 1);
    check("press_digit1_idle", int'(bus.digit1), 0);

    // Ten clean presses on digit2: 1..9 then wrap to 0
    upd_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      set_btn(2, 1'b1);
      wait_neg(8);
      set_btn(2, 1'b0);
      wait_neg(8);
      check("ten_press_digit2", int'(bus.digit2), (k + 1) % 10);
    end
    check("ten_press_upd", upd_cnt, 10);

    // Short glitches on digit1 never step
    upd_cnt = 0;
    repeat (5) begin
      set_btn(1, 1'b1);
      wait_neg(3);
      set_btn(1, 1'b0);
      wait_neg(3);
    end
    wait_neg(10);
    check("glitch_digit1", int'(bus.digit1), 0);
    check("glitch_upd", upd_cnt, 0);

    // Simultaneous presses on digit0 and digit3
    upd_cnt = 0;
    bus.in = 4'b1001;
    wait_neg(8);
    bus.in = 4'b0000;
    wait_neg(10);
    check("simul_digit0", int'(bus.digit0), 2);
    check("simul_digit3", int'(bus.digit3), 1);
    check("simul_one_upd", upd_cnt, 1);

    // Operation switches: three-cycle latency, priority decode
    bus.operations = 4'b1010;
    repeat (2) @(posedge clk);
    #1 check("op_1010_early", int'(bus.op_code), 0);
    @(posedge clk);
    #1 check("op_1010", int'(bus.op_code), 2);
    @(negedge clk);
    bus.operations = 4'b0000;
    repeat (3) @(posedge clk);
    #1 check("op_0000", int'(bus.op_code), 0);
    @(negedge clk);
    bus.operations = 4'b1000;
    repeat (3) @(posedge clk);
    #1 check("op_1000", int'(bus.op_code), 4);
    @(negedge clk);

    // Button held for 50 cycles
    upd_cnt = 0;
    set_btn(0, 1'b1);
    wait_neg(50);
    set_btn(0, 1'b0);
    wait_neg(15);
    check("held_upd_count", upd_cnt, HELD_STEPS);
    check("held_digit0", int'(bus.digit0), (2 + HELD_STEPS) % 10);

    // Reset asserted mid PRESS_WAIT: immediate clear, no later step
    set_btn(1, 1'b1);
    wait_neg(4);
    #2 rstn = 1'b0;
    #1;
    check("midrst_digit0", int'(bus.digit0), 0);
    check("midrst_digit3", int'(bus.digit3), 0);
    check("midrst_op_code", int'(bus.op_code), 0);
    check("midrst_upd", int'(bus.upd), 0);
    set_btn(1, 1'b0);
    wait_neg(2);
    rstn = 1'b1;
    upd_cnt = 0;
    wait_neg(12);
    check("midrst_no_step", int'(bus.digit1), 0);
    check("midrst_no_upd", upd_cnt, 0);

    // Press held across reset release counts as a new press
    set_btn(3, 1'b1);
    wait_neg(3);
    rstn = 1'b0;
    wait_neg(2);
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("heldrst_before", int'(bus.digit3), 0);
    @(posedge clk);
    #1 check("heldrst_step", int'(bus.digit3), 1);
    @(negedge clk);
    set_btn(3, 1'b0);
    wait_neg(10);

    // Randomized activity with an asynchronous reset pulse in the middle
    for (int b = 0; b < 4; b++) cd[b] = $urandom_range(12, 1);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++) begin
        if (cd[b] == 0) begin
          set_btn(b, ~bus.in[b]);
          cd[b] = $urandom_range(12, 1);
        end else begin
          cd[b]--;
        end
      end
      if ($urandom_range(39, 0) == 0) bus.operations = 4'($urandom_range(15, 0));
      if (c == 700) begin
        #2 rstn = 1'b0;
      end
      if (c == 703) rstn = 1'b1;
    end
    bus.in = 4'd0;
    wait_neg(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
